// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU opcodes, forwarding select and ID/EX payload type
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int ALU_OP_W  = 4;
  localparam int REG_IDX_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_NE  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_GE  = 4'd11;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // An all-zero payload is the bubble: invalid, no side-effecting controls.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 alu_src;
    logic                 pc_src;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - hazard forwarding select for one source operand
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src,
  input  logic [DATA_WIDTH-1:0]     reg_data,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     data
);

  fwd_sel_t sel;

  // The younger EX/MEM producer wins; x0 is hardwired and never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    data = reg_data;
    case (sel)
      FWD_EXMEM: data = exmem_result;
      FWD_MEMWB: data = memwb_result;
      default:   data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detect
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_alu_src,
  input  logic                      id_pc_src,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      id_branch,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_branch,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      load_use_stall
);

  id_ex_t ex_q;
  id_ex_t cap;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  // Side-effecting controls only survive when decode actually holds an instruction.
  always_comb begin
    cap           = '0;
    cap.valid     = id_valid;
    cap.pc        = id_pc;
    cap.rs1_data  = id_rs1_data;
    cap.rs2_data  = id_rs2_data;
    cap.imm       = id_imm;
    cap.rs1       = id_rs1;
    cap.rs2       = id_rs2;
    cap.rd        = id_rd;
    cap.alu_op    = id_alu_op;
    cap.alu_src   = id_alu_src;
    cap.pc_src    = id_pc_src;
    cap.reg_write = id_reg_write & id_valid;
    cap.mem_read  = id_mem_read & id_valid;
    cap.mem_write = id_mem_write & id_valid;
    cap.branch    = id_branch & id_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= cap;
    end
  end

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .src             (ex_q.rs1),
    .reg_data        (ex_q.rs1_data),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .data            (fwd_rs1)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .src             (ex_q.rs2),
    .reg_data        (ex_q.rs2_data),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .data            (fwd_rs2)
  );

  assign SrcA          = ex_q.pc_src ? ex_q.pc : fwd_rs1;
  assign SrcB          = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign Operation     = ex_q.valid ? ex_q.alu_op : ALU_AND;

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write & ex_q.valid;
  assign ex_mem_read  = ex_q.mem_read & ex_q.valid;
  assign ex_mem_write = ex_q.mem_write & ex_q.valid;
  assign ex_branch    = ex_q.branch & ex_q.valid;

  // A load in EX cannot feed the instruction in decode until it reaches MEM/WB.
  assign load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                          ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a reference model
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_pc_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic        stall, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] SrcA, SrcB, ex_pc, ex_store_data;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, load_use_stall;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction the EX slot should currently hold.
  logic        m_valid, m_alu_src, m_pc_src, m_rw, m_mr, m_mw, m_br;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_op;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_pc_src(id_pc_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .stall(stall), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    {m_valid, m_alu_src, m_pc_src, m_rw, m_mr, m_mw, m_br} = '0;
    {m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_op} = '0;
  endtask

  task automatic model_edge();
    if (flush) model_clear();
    else if (!stall) begin
      m_valid = id_valid;   m_pc = id_pc;       m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
      m_imm = id_imm;       m_rs1 = id_rs1;     m_rs2 = id_rs2;       m_rd = id_rd;
      m_op = id_alu_op;     m_alu_src = id_alu_src; m_pc_src = id_pc_src;
      m_rw = id_reg_write && id_valid; m_mr = id_mem_read && id_valid;
      m_mw = id_mem_write && id_valid; m_br = id_branch && id_valid;
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return rf;
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] a, b;
    a = operand(m_rs1, m_rs1d);
    b = operand(m_rs2, m_rs2d);
    chk({tag, ".SrcA"}, SrcA, m_pc_src ? m_pc : a);
    chk({tag, ".SrcB"}, SrcB, m_alu_src ? m_imm : b);
    chk({tag, ".store"}, ex_store_data, b);
    chk({tag, ".op"}, {28'd0, Operation}, m_valid ? {28'd0, m_op} : 32'd0);
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
    chk({tag, ".pc"}, ex_pc, m_pc);
    chk({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, m_rd});
    chk({tag, ".ctl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
        {28'd0, m_rw, m_mr, m_mw, m_br});
    chk({tag, ".lus"}, {31'd0, load_use_stall},
        {31'd0, m_valid && m_mr && m_rd != 0 && id_valid && (m_rd == id_rs1 || m_rd == id_rs2)});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [3:0] op,
                        input logic asrc, input logic psrc, input logic rw, input logic mr);
    id_valid = v; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_op = op; id_alu_src = asrc;
    id_pc_src = psrc; id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0; id_branch = 1'b0;
  endtask

  task automatic no_fwd();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    no_fwd();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Load something, then pull reset mid-cycle: state must clear without a clock edge.
    set_id(1, 32'h80, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 4'd6, 0, 0, 1, 1);
    tick();
    chk("pre_reset.valid", {31'd0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all("async_reset");
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Basic capture: ADD 5 + 7.
    set_id(1, 32'h4, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 4'b0010, 0, 0, 1, 0);
    tick();
    chk("add.SrcA", SrcA, 32'd5);
    chk("add.SrcB", SrcB, 32'd7);
    chk("add.op", {28'd0, Operation}, 32'd2);
    check_all("add");

    // EX/MEM beats MEM/WB for rs1=3; then MEM/WB alone.
    set_id(1, 32'h8, 32'h1, 32'h2, 32'd0, 5'd3, 5'd6, 5'd7, 4'b0010, 0, 0, 1, 0);
    tick();
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'h100;
    memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'h200;
    #1;
    chk("fwd_exmem.SrcA", SrcA, 32'h100);
    check_all("fwd_exmem");
    exmem_reg_write = 0;
    #1;
    chk("fwd_memwb.SrcA", SrcA, 32'h200);
    no_fwd();

    // x0 is never forwarded.
    set_id(1, 32'hC, 32'h9, 32'h0, 32'd0, 5'd1, 5'd0, 5'd2, 4'b0110, 0, 0, 1, 0);
    tick();
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hDEAD;
    #1;
    chk("x0.SrcB", SrcB, 32'h0);
    check_all("x0");
    no_fwd();

    // Load-use: load rd=4 in EX, dependent instruction in decode, bubble via flush.
    set_id(1, 32'h10, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd0, 5'd4, 4'b0010, 1, 0, 1, 1);
    tick();
    set_id(1, 32'h14, 32'h5, 32'h6, 32'h0, 5'd9, 5'd4, 5'd8, 4'b0100, 0, 0, 1, 0);
    #1;
    chk("load_use.stall", {31'd0, load_use_stall}, 32'd1);
    check_all("load_use");
    flush = 1;
    tick();
    flush = 0;
    chk("load_use.bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("load_use.bubble_op", {28'd0, Operation}, 32'd0);
    check_all("load_use_bubble");

    // Stall holds for two cycles while decode inputs change.
    set_id(1, 32'h20, 32'hA, 32'hB, 32'hC, 5'd10, 5'd11, 5'd12, 4'b0101, 0, 0, 1, 0);
    tick();
    stall = 1;
    set_id(1, 32'h24, 32'hAA, 32'hBB, 32'hCC, 5'd13, 5'd14, 5'd15, 4'b0001, 1, 1, 0, 1);
    tick();
    tick();
    chk("stall.pc", ex_pc, 32'h20);
    chk("stall.SrcA", SrcA, 32'hA);
    check_all("stall");
    flush = 1;
    tick();
    stall = 0; flush = 0;
    chk("stall_flush.valid", {31'd0, ex_valid}, 32'd0);
    chk("stall_flush.rw", {31'd0, ex_reg_write}, 32'd0);

    // PC/immediate operands; store data still forwarded from MEM/WB.
    set_id(1, 32'h40, 32'h1, 32'h2, 32'h1000, 5'd1, 5'd5, 5'd6, 4'b0010, 1, 1, 0, 0);
    id_mem_write = 1;
    tick();
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'hCAFE;
    #1;
    chk("pcimm.SrcA", SrcA, 32'h40);
    chk("pcimm.SrcB", SrcB, 32'h1000);
    chk("pcimm.store", ex_store_data, 32'hCAFE);
    check_all("pcimm");

    // Randomized traffic with a small register range so hazards are frequent.
    for (int i = 0; i < 300; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             4'($urandom_range(0, 11)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      id_mem_write = 1'($urandom); id_branch = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      #1;
      check_all("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding mux.
- Captures the decoded instruction from the decode stage each cycle.
- Resolves EX/MEM and MEM/WB data hazards, then drives SrcA/SrcB/Operation directly into the ALU.
- Detects load-use hazards and requests a decode stall; supports stall (hold) and flush (bubble insert).

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_LENGTH, 4, ALU Operation width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_pc  in  DATA_WIDTH  instruction PC
id_rs1_data  in  DATA_WIDTH  register-file read 1
id_rs2_data  in  DATA_WIDTH  register-file read 2
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1  in  REG_ADDR_WIDTH  source 1 index
id_rs2  in  REG_ADDR_WIDTH  source 2 index
id_rd  in  REG_ADDR_WIDTH  destination index
id_alu_op  in  OPCODE_LENGTH  ALU operation code
id_alu_src  in  1  1: SrcB = imm
id_pc_src  in  1  1: SrcA = PC (AUIPC/JAL)
id_reg_write  in  1  writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
id_branch  in  1  conditional branch
stall  in  1  hold EX register contents
flush  in  1  replace EX contents with bubble
exmem_rd  in  REG_ADDR_WIDTH  EX/MEM destination
exmem_reg_write  in  1  EX/MEM writes rd
exmem_result  in  DATA_WIDTH  EX/MEM ALU result
memwb_rd  in  REG_ADDR_WIDTH  MEM/WB destination
memwb_reg_write  in  1  MEM/WB writes rd
memwb_result  in  DATA_WIDTH  MEM/WB writeback data
SrcA  out  DATA_WIDTH  ALU operand A
SrcB  out  DATA_WIDTH  ALU operand B
Operation  out  OPCODE_LENGTH  ALU operation
ex_valid  out  1  EX slot valid
ex_pc  out  DATA_WIDTH  registered PC
ex_rd  out  REG_ADDR_WIDTH  registered rd
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  registered controls, gated by ex_valid
ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
load_use_stall  out  1  stall request to fetch/decode

Behaviour:
- Reset (rst_n low, async): all registered fields cleared. ex_valid=0, all controls=0, Operation=4'b0000, ex_pc=0, ex_rd=0. SrcA/SrcB/ex_store_data=0, since the register-0 indices never forward. load_use_stall=0.
- Each rising edge, priority order:
  - flush=1: load bubble (valid=0, controls=0, data fields 0). Flush beats stall.
  - else stall=1: hold all registers.
  - else: capture all id_* fields. Captured controls are ANDed with id_valid.
- Latency: one cycle from id_* capture to SrcA/SrcB/Operation. Forwarding muxes are combinational on the registered fields plus the live exmem_*/memwb_* inputs.
- Forwarding, per source (rs1, rs2):
  - EX/MEM has priority when exmem_reg_write=1, exmem_rd!=0 and exmem_rd==src.
  - Else MEM/WB when memwb_reg_write=1, memwb_rd!=0 and memwb_rd==src.
  - Else the registered register-file data.
  - Register 0 is never forwarded; its value is the registered data.
- Operand selection:
  - SrcA = ex_pc_src ? ex_pc : fwd_rs1.
  - SrcB = ex_alu_src ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 regardless of alu_src.
- When ex_valid=0: Operation forced to 4'b0000. SrcA/SrcB still follow the muxes (don't-care downstream).
- load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). The external controller responds by asserting flush on this stage for that cycle, inserting the bubble.
- Reset asserted mid-operation clears state immediately, independent of clk. Deassertion takes effect at the next edge.

Decomposition:
- Shared package riscv_pkg:
  - ALU opcode constants: AND, OR, ADD, SLL, XOR, SRL, SUB, EQ, NE, SRA, SLT, GE.
  - Forwarding-select enum: FWD_REG, FWD_EXMEM, FWD_MEMWB.
  - Packed struct id_ex_t for the pipeline register payload.
- One sub-module, fwd_mux: selection logic for a single source operand, instantiated twice.

Test Plan:
- Reset/capture: rst_n low mid-cycle → all ex_* outputs 0 immediately. After release, id ADD with rs1_data=5, rs2_data=7, alu_src=0 → next cycle SrcA=5, SrcB=7, Operation=4'b0010.
- EX/MEM forwarding: EX instr rs1=3; exmem_rd=3, exmem_reg_write=1, exmem_result=0x100, and memwb_rd=3 with memwb_result=0x200 → SrcA=0x100.
- x0 guard: rs2=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xDEAD → SrcB equals registered rs2_data (0).
- Load-use: EX holds a load with rd=4; id_rs2=4, id_valid=1 → load_use_stall=1. With flush=1 that edge → ex_valid=0 next cycle and Operation=0.
- Stall vs flush: stall=1 alone for 2 cycles → ex_* unchanged. stall=1 and flush=1 together → bubble (ex_valid=0, ex_reg_write=0).
- Immediate/PC select: pc_src=1, alu_src=1, pc=0x40, imm=0x1000 → SrcA=0x40, SrcB=0x1000. ex_store_data still equals forwarded rs2.
